// File: rtl/peripheral_uart_fifo_pkg.sv
// Shared defaults and the wrap-around pointer helper for the UART byte FIFO.
package peripheral_uart_fifo_pkg;

    localparam int unsigned UART_FIFO_DATA_WIDTH    = 8;
    localparam int unsigned UART_FIFO_DEPTH         = 16;
    localparam int unsigned UART_FIFO_TIMEOUT_WIDTH = 16;

    // Explicit wrap so that non-power-of-two depths index correctly
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/peripheral_uart_fifo_timeout.sv
// 16550-style character timeout: idle counter that saturates at the threshold.
module peripheral_uart_fifo_timeout
    import peripheral_uart_fifo_pkg::*;
#(
    parameter int unsigned TIMEOUT_WIDTH = UART_FIFO_TIMEOUT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clr_i,
    input  logic                     empty_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles_i,
    output logic                     timeout_o
);

    logic [TIMEOUT_WIDTH-1:0] idle_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idle_cnt <= '0;
        end else if (clr_i || empty_i || push_i || pop_i || (timeout_cycles_i == '0)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != timeout_cycles_i) begin
            idle_cnt <= idle_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    assign timeout_o = (idle_cnt == timeout_cycles_i) && !empty_i && (timeout_cycles_i != '0);

endmodule

// File: rtl/peripheral_uart_fifo_trig.sv
// UART byte FIFO with trigger level, empty/full, sticky overflow and optional
// character timeout (enabled by defining PERIPHERAL_UART_FIFO_TIMEOUT_EN).
module peripheral_uart_fifo_trig
    import peripheral_uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = UART_FIFO_DATA_WIDTH,
    parameter int unsigned BUFFER_DEPTH     = UART_FIFO_DEPTH,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
    parameter int unsigned TIMEOUT_WIDTH    = UART_FIFO_TIMEOUT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clr_i,
    input  logic [LOG_BUFFER_DEPTH:0]   trig_level_i,
    input  logic                        ovf_clr_i,
    input  logic [TIMEOUT_WIDTH-1:0]    timeout_cycles_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic                        ready_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        trig_o,
    output logic                        overflow_o,
    output logic                        timeout_o
);

    localparam int unsigned CW = LOG_BUFFER_DEPTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(BUFFER_DEPTH);

    logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [LOG_BUFFER_DEPTH-1:0]             wr_ptr;
    logic [LOG_BUFFER_DEPTH-1:0]             rd_ptr;
    logic [CW-1:0]                           count;
    logic [CW-1:0]                           trig_thr;
    logic                                    full;
    logic                                    empty;
    logic                                    push;
    logic                                    pop;
    logic                                    overflow;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign push  = valid_i && !full;
    assign pop   = !empty && ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // A write into a full FIFO sets the flag even against a same-cycle clear
            if (valid_i && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr_i || clr_i) begin
                overflow <= 1'b0;
            end

            if (clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= data_i;
                    wr_ptr      <= LOG_BUFFER_DEPTH'(ptr_inc(32'(wr_ptr), BUFFER_DEPTH));
                end
                if (pop) begin
                    rd_ptr <= LOG_BUFFER_DEPTH'(ptr_inc(32'(rd_ptr), BUFFER_DEPTH));
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Levels above the depth saturate, making the trigger equivalent to full
    assign trig_thr = (trig_level_i > DEPTH_CNT) ? DEPTH_CNT : trig_level_i;
    assign trig_o   = (trig_level_i != '0) && (count >= trig_thr);

    assign ready_o    = !full;
    assign valid_o    = !empty;
    assign data_o     = mem[rd_ptr];
    assign elements_o = count;
    assign empty_o    = empty;
    assign full_o     = full;
    assign overflow_o = overflow;

`ifdef PERIPHERAL_UART_FIFO_TIMEOUT_EN
    peripheral_uart_fifo_timeout #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_timeout (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .clr_i           (clr_i),
        .empty_i         (empty),
        .push_i          (push),
        .pop_i           (pop),
        .timeout_cycles_i(timeout_cycles_i),
        .timeout_o       (timeout_o)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles_i;
    assign timeout_o      = 1'b0;
`endif

endmodule
